// File: rtl/psram_txn_ctrl.sv
// psram_txn_ctrl: host-side sequencer that turns single 16-bit read/write
// requests into read_sw/write_sw levels for the PSRAM block, tracks mem_ce
// low-then-high to detect completion, and returns a one-cycle response.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_INIT    | PSRAM not yet in QPI idle; no requests accepted
// S_IDLE    | ready for a request
// S_ARM     | one clock to raise the read/write switch
// S_WAIT_LO | switch held, waiting for mem_ce to fall
// S_WAIT_HI | switch held, waiting for mem_ce to return high
// S_GAP     | switches low, enforcing CE-high time before the next accept
module psram_txn_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 64,
   parameter int unsigned GAP_CYCLES     = 2,
   parameter int unsigned TIMER_W        = 8
) (
   input  logic        mem_clk,
   input  logic        rst,
   input  logic        init_done,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [23:0] req_addr,
   input  logic [15:0] req_wdata,
   output logic        rsp_valid,
   output logic [15:0] rsp_rdata,
   output logic        rsp_err,
   output logic [23:0] address,
   output logic        read_sw,
   output logic        write_sw,
   output logic [15:0] data_in,
   input  logic        mem_ce,
   input  logic [15:0] data_out
);

   typedef enum logic [2:0] {
      S_INIT, S_IDLE, S_ARM, S_WAIT_LO, S_WAIT_HI, S_GAP
   } state_t;

   localparam logic [TIMER_W-1:0] TO_LAST  = TIMER_W'(TIMEOUT_CYCLES - 1);
   localparam logic [TIMER_W-1:0] GAP_LAST = TIMER_W'(GAP_CYCLES);

   state_t              state_q, state_d;
   logic [TIMER_W-1:0]  timer_q, timer_d;
   logic                we_q, we_d;
   logic                req_ready_q, req_ready_d;
   logic                read_sw_q, read_sw_d;
   logic                write_sw_q, write_sw_d;
   logic [23:0]         addr_q, addr_d;
   logic [15:0]         wdata_q, wdata_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic [15:0]         rsp_rdata_q, rsp_rdata_d;
   logic                rsp_err_q, rsp_err_d;

   logic waiting, done, tmo, accept, gap_end;

   assign waiting = (state_q == S_WAIT_LO) || (state_q == S_WAIT_HI);
   assign done    = (state_q == S_WAIT_HI) && mem_ce;
   // completion wins over timeout when both land on the same edge
   assign tmo     = waiting && (timer_q == TO_LAST) && !done;
   assign accept  = (state_q == S_IDLE) && init_done && req_valid && req_ready_q;
   assign gap_end = (state_q == S_GAP) && (timer_q == GAP_LAST);

   // state and registered outputs, synchronous reset
   always_ff @(posedge mem_clk) begin
      if (rst) begin
         state_q     <= S_INIT;
         timer_q     <= '0;
         we_q        <= 1'b0;
         req_ready_q <= 1'b0;
         read_sw_q   <= 1'b0;
         write_sw_q  <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         we_q        <= we_d;
         req_ready_q <= req_ready_d;
         read_sw_q   <= read_sw_d;
         write_sw_q  <= write_sw_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   // next-state selection
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_INIT:    if (init_done) state_d = S_IDLE;
         S_IDLE: begin
            if (!init_done)  state_d = S_INIT;
            else if (accept) state_d = S_ARM;
         end
         S_ARM:     state_d = S_WAIT_LO;
         S_WAIT_LO: begin
            if (tmo)         state_d = S_GAP;
            else if (!mem_ce) state_d = S_WAIT_HI;
         end
         S_WAIT_HI: if (done || tmo) state_d = S_GAP;
         S_GAP:     if (gap_end) state_d = init_done ? S_IDLE : S_INIT;
         default:   state_d = S_INIT;
      endcase
   end

   // next values of the registered outputs, timer and latched request
   always_comb begin
      timer_d     = timer_q;
      we_d        = we_q;
      req_ready_d = (state_d == S_IDLE);
      read_sw_d   = read_sw_q;
      write_sw_d  = write_sw_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               addr_d = req_addr;
               we_d   = req_we;
               if (req_we) wdata_d = req_wdata;
            end
         end
         S_ARM: begin
            write_sw_d = we_q;
            read_sw_d  = !we_q;
            timer_d    = '0;
         end
         S_WAIT_LO, S_WAIT_HI: begin
            if (done) begin
               read_sw_d   = 1'b0;
               write_sw_d  = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b0;
               if (!we_q) rsp_rdata_d = data_out;
               timer_d     = '0;
            end else if (tmo) begin
               read_sw_d   = 1'b0;
               write_sw_d  = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
               rsp_rdata_d = '0;
               timer_d     = '0;
            end else begin
               timer_d = timer_q + TIMER_W'(1);
            end
         end
         S_GAP:   timer_d = gap_end ? '0 : timer_q + TIMER_W'(1);
         default: ;
      endcase
   end

   assign req_ready = req_ready_q;
   assign read_sw   = read_sw_q;
   assign write_sw  = write_sw_q;
   assign address   = addr_q;
   assign data_in   = wdata_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_psram_txn_ctrl.sv
// Bench for psram_txn_ctrl: directed requests against a small PSRAM model,
// expected responses queued at issue time and checked by a separate monitor.
module tb_psram_txn_ctrl;

   localparam int TIMEOUT_CYCLES = 64;
   localparam int GAP_CYCLES     = 2;
   localparam int TIMER_W        = 8;

   logic        mem_clk = 1'b0;
   logic        rst, init_done, req_valid, req_we;
   logic [23:0] req_addr;
   logic [15:0] req_wdata;
   logic        req_ready, rsp_valid, rsp_err, read_sw, write_sw, mem_ce;
   logic [15:0] rsp_rdata, data_in, data_out;
   logic [23:0] address;

   psram_txn_ctrl #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
      .GAP_CYCLES(GAP_CYCLES),
      .TIMER_W(TIMER_W)
   ) dut (
      .mem_clk(mem_clk), .rst(rst), .init_done(init_done),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .address(address), .read_sw(read_sw), .write_sw(write_sw),
      .data_in(data_in), .mem_ce(mem_ce), .data_out(data_out)
   );

   always #5 mem_clk = ~mem_clk;

   typedef struct packed {
      logic        err;
      logic [15:0] rdata;
   } rsp_t;

   rsp_t        exp_q[$];
   rsp_t        e_mon;
   int          total = 0;
   int          bad   = 0;
   int          cyc   = 0;
   int          rsp_cnt = 0;
   int          acc_cnt = 0;
   int          last_rsp_cyc = 0;
   int          gap_meas = -1;
   logic        prev_ready = 1'b0;
   logic        psram_dead = 1'b0;
   logic [15:0] mem [logic [23:0]];

   function automatic rsp_t mk(input logic err, input logic [15:0] rdata);
      rsp_t r;
      r.err   = err;
      r.rdata = rdata;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge mem_clk);
      #1;
   endtask

   task automatic wait_accept(input string name);
      int n = 0;
      while (req_ready !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      total++;
      if (req_ready !== 1'b1) begin
         bad++;
         $display("FAIL %s: got req_ready=%b want 1 within 200 clocks", name, req_ready);
      end
      tick();
      req_valid = 1'b0;
   endtask

   task automatic wait_rsp(input string name, input int target);
      int n = 0;
      while (rsp_cnt < target && n < 300) begin
         tick();
         n++;
      end
      total++;
      if (rsp_cnt < target) begin
         bad++;
         $display("FAIL %s: got %0d responses want %0d", name, rsp_cnt, target);
      end
   endtask

   task automatic wait_ce_low(input string name);
      int n = 0;
      while (mem_ce !== 1'b0 && n < 200) begin
         tick();
         n++;
      end
      total++;
      if (mem_ce !== 1'b0) begin
         bad++;
         $display("FAIL %s: got mem_ce=%b want 0 within 200 clocks", name, mem_ce);
      end
   endtask

   // cycle counter
   initial forever begin
      @(posedge mem_clk);
      cyc++;
   end

   // PSRAM model: CE falls two clocks after a switch rises, stays low four
   // clocks, then rises with read data; waits for the switch to drop
   initial begin
      mem_ce   = 1'b1;
      data_out = 16'h0000;
      forever begin
         @(negedge mem_clk);
         if ((read_sw === 1'b1 || write_sw === 1'b1) && !psram_dead) begin
            repeat (2) @(negedge mem_clk);
            mem_ce = 1'b0;
            if (write_sw === 1'b1) mem[address] = data_in;
            repeat (4) @(negedge mem_clk);
            if (read_sw === 1'b1 && mem.exists(address)) data_out = mem[address];
            mem_ce = 1'b1;
            while (read_sw === 1'b1 || write_sw === 1'b1) @(negedge mem_clk);
         end
      end
   end

   // response monitor and scoreboard
   initial forever begin
      @(negedge mem_clk);
      if (rsp_valid === 1'b1) begin
         rsp_cnt++;
         last_rsp_cyc = cyc;
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_rsp: got rsp_valid=1 err=%b rdata=%h want no response",
                     rsp_err, rsp_rdata);
         end else begin
            e_mon = exp_q.pop_front();
            chk("rsp_err", {31'd0, rsp_err}, {31'd0, e_mon.err});
            chk("rsp_rdata", {16'd0, rsp_rdata}, {16'd0, e_mon.rdata});
         end
      end
      if (req_ready === 1'b1 && req_valid === 1'b1) acc_cnt++;
      if (req_ready === 1'b1 && prev_ready !== 1'b1) gap_meas = cyc - last_rsp_cyc;
      prev_ready = req_ready;
      if (read_sw === 1'b1 && write_sw === 1'b1) begin
         total++;
         bad++;
         $display("FAIL both_sw: got read_sw=1 write_sw=1 want at most one high");
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got no finish want finish before 300000");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int   base_acc, base_rsp;
      logic ok;
      rst       = 1'b1;
      init_done = 1'b0;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = 24'h0;
      req_wdata = 16'h0;
      mem[24'h000200] = 16'hABCD;

      // reset values
      repeat (3) tick();
      chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
      chk("rst_read_sw",   {31'd0, read_sw},   32'd0);
      chk("rst_write_sw",  {31'd0, write_sw},  32'd0);
      chk("rst_address",   {8'd0, address},    32'd0);
      chk("rst_data_in",   {16'd0, data_in},   32'd0);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_rsp_rdata", {16'd0, rsp_rdata}, 32'd0);
      chk("rst_rsp_err",   {31'd0, rsp_err},   32'd0);

      // init_done low: request must wait
      rst       = 1'b0;
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = 24'h000100;
      req_wdata = 16'h1234;
      ok = 1'b1;
      repeat (100) begin
         tick();
         if (req_ready !== 1'b0 || read_sw !== 1'b0 || write_sw !== 1'b0) ok = 1'b0;
      end
      chk("init_hold", {31'd0, ok}, 32'd1);

      // first write
      init_done = 1'b1;
      exp_q.push_back(mk(1'b0, 16'h0000));
      tick();
      chk("ready_after_init", {31'd0, req_ready}, 32'd1);
      tick();
      req_valid = 1'b0;
      chk("wr_accept_ready", {31'd0, req_ready}, 32'd0);
      chk("wr_address", {8'd0, address}, 32'h000100);
      chk("wr_data_in", {16'd0, data_in}, 32'h1234);
      tick();
      chk("wr_write_sw", {31'd0, write_sw}, 32'd1);
      chk("wr_read_sw",  {31'd0, read_sw},  32'd0);
      wait_ce_low("wr_ce_low");
      ok = 1'b1;
      while (mem_ce === 1'b0) begin
         if (write_sw !== 1'b1) ok = 1'b0;
         tick();
      end
      chk("wr_sw_held", {31'd0, ok}, 32'd1);
      chk("wr_sw_drop", {31'd0, write_sw}, 32'd0);
      chk("wr_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      tick();
      chk("wr_rsp_one_clk", {31'd0, rsp_valid}, 32'd0);
      chk("wr_mem", {16'd0, mem[24'h000100]}, 32'h1234);
      repeat (4) tick();

      // read
      req_we    = 1'b0;
      req_addr  = 24'h000200;
      req_wdata = 16'hFFFF;
      req_valid = 1'b1;
      base_rsp  = rsp_cnt;
      exp_q.push_back(mk(1'b0, 16'hABCD));
      wait_accept("rd_accept");
      chk("rd_address", {8'd0, address}, 32'h000200);
      chk("rd_data_in_kept", {16'd0, data_in}, 32'h1234);
      tick();
      chk("rd_read_sw",  {31'd0, read_sw},  32'd1);
      chk("rd_write_sw", {31'd0, write_sw}, 32'd0);
      wait_rsp("rd_rsp", base_rsp + 1);
      repeat (5) tick();

      // request held valid across two write transactions
      base_acc  = acc_cnt;
      base_rsp  = rsp_cnt;
      req_we    = 1'b1;
      req_addr  = 24'h000600;
      req_wdata = 16'h7777;
      exp_q.push_back(mk(1'b0, 16'hABCD));
      exp_q.push_back(mk(1'b0, 16'hABCD));
      req_valid = 1'b1;
      for (int i = 0; i < 300 && acc_cnt < base_acc + 2; i++) tick();
      req_valid = 1'b0;
      chk("held_gap", gap_meas, GAP_CYCLES + 1);
      wait_rsp("held_rsp", base_rsp + 2);
      repeat (10) tick();
      chk("held_accepts", acc_cnt - base_acc, 32'd2);
      chk("held_mem", {16'd0, mem[24'h000600]}, 32'h7777);

      // read timeout: PSRAM never drops CE
      psram_dead = 1'b1;
      req_we     = 1'b0;
      req_addr   = 24'h000300;
      req_valid  = 1'b1;
      exp_q.push_back(mk(1'b1, 16'h0000));
      wait_accept("to_accept");
      ok = 1'b1;
      for (int i = 0; i < TIMEOUT_CYCLES; i++) begin
         tick();
         if (read_sw !== 1'b1 || rsp_valid !== 1'b0) ok = 1'b0;
      end
      chk("to_sw_hold", {31'd0, ok}, 32'd1);
      tick();
      chk("to_sw_drop", {31'd0, read_sw}, 32'd0);
      chk("to_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      psram_dead = 1'b0;
      repeat (6) tick();

      // reset during S_WAIT_HI of a write
      req_we    = 1'b1;
      req_addr  = 24'h000400;
      req_wdata = 16'h5555;
      req_valid = 1'b1;
      wait_accept("rst_wr_accept");
      wait_ce_low("rst_wr_ce_low");
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_mid_write_sw", {31'd0, write_sw}, 32'd0);
      chk("rst_mid_ready", {31'd0, req_ready}, 32'd0);
      chk("rst_mid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      tick();
      chk("rst_mid_ready_back", {31'd0, req_ready}, 32'd1);
      repeat (3) tick();
      base_rsp  = rsp_cnt;
      req_addr  = 24'h000500;
      req_wdata = 16'h6666;
      req_valid = 1'b1;
      exp_q.push_back(mk(1'b0, 16'h0000));
      wait_accept("post_rst_accept");
      wait_rsp("post_rst_rsp", base_rsp + 1);
      repeat (6) tick();
      chk("post_rst_mem", {16'd0, mem[24'h000500]}, 32'h6666);
      chk("queue_empty", exp_q.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
